// File: rtl/sfr04_pkg.sv
// Shared types and constants for the SRF04 range converter.
package sfr04_pkg;

  localparam int W_IN             = 16;
  localparam int W_CM             = 10;
  localparam int AVG_TAPS         = 4;
  localparam int W_SUM            = 12;
  localparam int TICKS_PER_CM_DEF = 58;
  localparam int MAX_CM_DEF       = 400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_POST = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/sfr04_range_conv_udiv.sv
// Generic sequential restoring unsigned divider: one quotient bit per cycle,
// W_N cycles from start to a one-cycle done pulse; quotient holds until the next start.
module sfr04_udiv #(
  parameter int W_N = 17,
  parameter int W_D = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W_N-1:0] dividend,
  input  logic [W_D-1:0] divisor,
  output logic           done,
  output logic [W_N-1:0] quotient
);

  localparam int W_CNT = $clog2(W_N + 1);

  logic [W_D-1:0]   r_rem;
  logic [W_N-1:0]   r_quo;
  logic [W_CNT-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [W_D:0]     w_shift;
  logic             w_ge;
  logic [W_D-1:0]   w_diff;

  // The dividend shifts out of r_quo's MSB while quotient bits shift in at the LSB.
  assign w_shift = {r_rem, r_quo[W_N-1]};
  assign w_ge    = (w_shift >= {1'b0, divisor});
  assign w_diff  = w_shift[W_D-1:0] - divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start && !r_busy) begin
        r_quo  <= dividend;
        r_rem  <= '0;
        r_cnt  <= W_CNT'(W_N);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_ge ? w_diff : w_shift[W_D-1:0];
        r_quo <= {r_quo[W_N-2:0], w_ge};
        r_cnt <= r_cnt - W_CNT'(1);
        if (r_cnt == W_CNT'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done     = r_done;
  assign quotient = r_quo;

endmodule

// File: rtl/sfr04_range_conv.sv
// SRF04 echo ticks -> centimetres, rounded half-up, clamped and flagged.
// Define RANGE_AVG_EN to add a 4-tap moving average over in-range results.
module sfr04_range_conv
  import sfr04_pkg::*;
#(
  parameter int TICKS_PER_CM = TICKS_PER_CM_DEF,
  parameter int MAX_CM       = MAX_CM_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W_IN-1:0] raw_ticks,
  input  logic            raw_valid,
  output logic [W_CM-1:0] dist_cm,
  output logic            dist_valid,
  output logic            out_of_range,
  output logic            busy,
  output logic            overrun,
  output logic [1:0]      o_dbg_state
);

  localparam int W_DIVD = W_IN + 1;
  localparam int W_DVSR = $clog2(TICKS_PER_CM + 1);
  localparam logic [W_DIVD-1:0] BIAS    = W_DIVD'(TICKS_PER_CM / 2);
  localparam logic [W_DVSR-1:0] DIVISOR = W_DVSR'(TICKS_PER_CM);
  localparam logic [W_DIVD-1:0] MAX_Q   = W_DIVD'(MAX_CM);
  localparam logic [W_CM-1:0]   MAX_VAL = W_CM'(MAX_CM);

  state_t            r_state;
  state_t            w_next;
  logic              w_start;
  logic              w_div_done;
  logic [W_DIVD-1:0] w_dividend;
  logic [W_DIVD-1:0] w_quo;

  logic              r_raw_zero;
  logic [W_CM-1:0]   r_post_dist;
  logic              r_post_oor;
  logic [W_CM-1:0]   r_dist_cm;
  logic              r_dist_valid;
  logic              r_oor;
  logic              r_overrun;

  logic [W_CM-1:0]   w_res_raw;
  logic              w_oor_raw;
  logic [W_CM-1:0]   w_res;

  // Bias for half-up rounding is added here; 17 bits so 0xFFFF + bias cannot wrap.
  assign w_dividend = {1'b0, raw_ticks} + BIAS;

  sfr04_udiv #(
    .W_N (W_DIVD),
    .W_D (W_DVSR)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .dividend (w_dividend),
    .divisor  (DIVISOR),
    .done     (w_div_done),
    .quotient (w_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (raw_valid) begin
          w_next  = ST_DIV;
          w_start = 1'b1;
        end
      end
      ST_DIV:  if (w_div_done) w_next = ST_POST;
      ST_POST: w_next = ST_OUT;
      ST_OUT:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Clamp / flag the single-sample result.
  always_comb begin
    w_res_raw = w_quo[W_CM-1:0];
    w_oor_raw = 1'b0;
    if (r_raw_zero || (w_quo == '0)) begin
      w_res_raw = '0;
      w_oor_raw = 1'b1;
    end else if (w_quo > MAX_Q) begin
      w_res_raw = MAX_VAL;
      w_oor_raw = 1'b1;
    end
  end

`ifdef RANGE_AVG_EN
  logic [W_CM-1:0]  r_hist [AVG_TAPS];
  logic             r_hist_vld;
  logic [W_SUM-1:0] w_sum;
  logic [W_SUM-1:0] w_avg_full;

  // Window is the new sample plus the newest AVG_TAPS-1 history entries;
  // an empty history behaves as if every tap already held the new sample.
  always_comb begin
    w_sum = W_SUM'(w_res_raw);
    for (int i = 0; i < AVG_TAPS - 1; i++) begin
      w_sum = w_sum + (r_hist_vld ? W_SUM'(r_hist[i]) : W_SUM'(w_res_raw));
    end
    w_avg_full = w_sum >> $clog2(AVG_TAPS);
  end

  assign w_res = w_oor_raw ? w_res_raw : w_avg_full[W_CM-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AVG_TAPS; i++) r_hist[i] <= '0;
      r_hist_vld <= 1'b0;
    end else if (r_state == ST_POST && !w_oor_raw) begin
      r_hist_vld <= 1'b1;
      r_hist[0]  <= w_res_raw;
      for (int i = 1; i < AVG_TAPS; i++) begin
        r_hist[i] <= r_hist_vld ? r_hist[i-1] : w_res_raw;
      end
    end
  end
`else
  assign w_res = w_res_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw_zero   <= 1'b0;
      r_post_dist  <= '0;
      r_post_oor   <= 1'b0;
      r_dist_cm    <= '0;
      r_dist_valid <= 1'b0;
      r_oor        <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_dist_valid <= 1'b0;
      if (w_start) r_raw_zero <= (raw_ticks == '0);
      if (raw_valid && r_state != ST_IDLE) r_overrun <= 1'b1;
      if (r_state == ST_POST) begin
        r_post_dist <= w_res;
        r_post_oor  <= w_oor_raw;
      end
      if (r_state == ST_OUT) begin
        r_dist_cm    <= r_post_dist;
        r_oor        <= r_post_oor;
        r_dist_valid <= 1'b1;
      end
    end
  end

  assign dist_cm      = r_dist_cm;
  assign dist_valid   = r_dist_valid;
  assign out_of_range = r_oor;
  assign overrun      = r_overrun;
  assign busy         = (r_state != ST_IDLE);
  assign o_dbg_state  = r_state;

endmodule
